// File: rtl/disp_scroll_ctrl.sv
// Scan/scroll controller for a 12-digit 14-segment display: a 16-entry message
// buffer is multiplexed onto one-hot digit selects, with optional circular scroll.
module disp_scroll_ctrl #(
    parameter int SCAN_DIV   = 4,
    parameter int SCROLL_DIV = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [3:0]  wr_addr,
    input  logic [4:0]  wr_char,
    input  logic [4:0]  msg_len,
    input  logic        scroll_en,
    output logic [11:0] sel,
    output logic [13:0] segm,
    output logic        frame_done
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(SCAN_DIV - 1);
    localparam logic [FW-1:0] FMAX = FW'(SCROLL_DIV - 1);

    typedef struct packed {
        logic       en;
        logic [3:0] addr;
        logic [4:0] chr;
    } wr_req_t;

    function automatic logic [13:0] font(input logic [4:0] c);
        logic [13:0] f;
        case (c)
            5'd1:    f = 14'b11101111000000; // A
            5'd2:    f = 14'b11110001010010;
            5'd3:    f = 14'b10011100000000;
            5'd4:    f = 14'b11110000010010;
            5'd5:    f = 14'b10011111000000;
            5'd6:    f = 14'b10001110000000;
            5'd7:    f = 14'b10111101000000;
            5'd8:    f = 14'b01101111000000;
            5'd9:    f = 14'b10010000010010;
            5'd10:   f = 14'b01111000000000; // J
            5'd11:   f = 14'b00001110001100;
            5'd12:   f = 14'b00011100000000; // L
            5'd13:   f = 14'b01101100101000;
            5'd14:   f = 14'b01101100100100; // N
            5'd15:   f = 14'b11111100000000;
            5'd16:   f = 14'b11001111000000; // P
            5'd17:   f = 14'b11111100000100;
            5'd18:   f = 14'b11001111000100;
            5'd19:   f = 14'b10110111000000;
            5'd20:   f = 14'b10000000010010; // T
            5'd21:   f = 14'b01111100000000; // U
            5'd22:   f = 14'b00001100001001;
            5'd23:   f = 14'b01101100000101;
            5'd24:   f = 14'b00000000101101; // X
            5'd25:   f = 14'b00000000101010;
            5'd26:   f = 14'b10010000001001;
            default: f = 14'b0;
        endcase
        return f;
    endfunction

    wr_req_t          wr_req;
    logic [15:0][4:0] buf_q;

    logic             started_q;
    logic [PW-1:0]    presc_q;
    logic [3:0]       digit_q, ptr_q, offset_q;
    logic [4:0]       len_q;
    logic             scroll_q;
    logic [FW-1:0]    fcnt_q;
    logic [11:0]      sel_q;
    logic [13:0]      segm_q;
    logic             fd_q;

    logic             slot_start, boundary, scroll_eff;
    logic [3:0]       digit_d, ptr_d, offset_d;
    logic [4:0]       len_new, len_eff, off_inc, ptr_inc, chr;
    logic [FW-1:0]    fcnt_d;

    assign wr_req = '{en: wr_en, addr: wr_addr, chr: wr_char};

    always_comb begin
        slot_start = !started_q || (presc_q == PMAX);
        digit_d    = (!started_q || digit_q == 4'd11) ? 4'd0 : digit_q + 4'd1;
        boundary   = slot_start && (digit_d == 4'd0);
        len_new    = (msg_len == 5'd0) ? 5'd1 : ((msg_len > 5'd16) ? 5'd16 : msg_len);

        // Scroll bookkeeping counts frames that were displayed with scrolling on.
        fcnt_d  = '0;
        off_inc = '0;
        if (scroll_q) begin
            if (fcnt_q == FMAX) begin
                fcnt_d  = '0;
                off_inc = {1'b0, offset_q} + 5'd1;
            end else begin
                fcnt_d  = fcnt_q + FW'(1);
                off_inc = {1'b0, offset_q};
            end
        end
        // One compare covers both the circular wrap and a shrinking length.
        offset_d = (off_inc >= len_new) ? 4'd0 : off_inc[3:0];

        ptr_inc = {1'b0, ptr_q} + 5'd1;
        ptr_d   = boundary ? offset_d : ((ptr_inc == len_q) ? 4'd0 : ptr_inc[3:0]);

        len_eff    = boundary ? len_new : len_q;
        scroll_eff = boundary ? scroll_en : scroll_q;

        chr = '0;
        if (scroll_eff)
            chr = buf_q[ptr_d];
        else if ({1'b0, digit_d} < len_eff)
            chr = buf_q[digit_d];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            started_q <= 1'b0;
            presc_q   <= '0;
            digit_q   <= '0;
            ptr_q     <= '0;
            offset_q  <= '0;
            len_q     <= 5'd1;
            scroll_q  <= 1'b0;
            fcnt_q    <= '0;
            sel_q     <= '0;
            segm_q    <= '0;
            fd_q      <= 1'b0;
            buf_q     <= '0;
        end else begin
            started_q <= 1'b1;
            presc_q   <= slot_start ? '0 : presc_q + PW'(1);
            fd_q      <= boundary && started_q;
            if (slot_start) begin
                digit_q <= digit_d;
                ptr_q   <= ptr_d;
                sel_q   <= 12'b1 << digit_d;
                segm_q  <= font(chr);
            end
            if (boundary) begin
                len_q    <= len_new;
                scroll_q <= scroll_en;
                offset_q <= offset_d;
                fcnt_q   <= fcnt_d;
            end
            // Buffer read above uses pre-edge contents, so a same-edge write shows next scan.
            for (int i = 0; i < 16; i++)
                if (wr_req.en && wr_req.addr == 4'(i))
                    buf_q[i] <= wr_req.chr;
        end
    end

    assign sel        = sel_q;
    assign segm       = segm_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_disp_scroll_ctrl.sv
// Randomized scoreboard bench for disp_scroll_ctrl against a frame-level reference model.
module tb_disp_scroll_ctrl;
    localparam int S  = 2;
    localparam int SD = 2;

    logic        clk = 1'b0;
    logic        rst, wr_en, scroll_en;
    logic [3:0]  wr_addr;
    logic [4:0]  wr_char, msg_len;
    logic [11:0] sel;
    logic [13:0] segm;
    logic        frame_done;

    always #5 clk = ~clk;

    disp_scroll_ctrl #(.SCAN_DIV(S), .SCROLL_DIV(SD)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
        .msg_len(msg_len), .scroll_en(scroll_en),
        .sel(sel), .segm(segm), .frame_done(frame_done)
    );

    typedef struct {
        logic [11:0] sel;
        logic [13:0] segm;
        logic        fd;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;

    // reference model state
    bit          m_started;
    int          tc, m_len, m_off, m_fcnt;
    bit          m_scroll;
    logic [4:0]  m_buf[16];
    logic [11:0] m_sel;
    logic [13:0] m_segm;

    int codes[11] = '{0, 1, 10, 12, 14, 16, 20, 21, 24, 27, 31};

    function automatic logic [13:0] font(input int c);
        case (c)
            1:  return 14'b11101111000000;
            10: return 14'b01111000000000;
            12: return 14'b00011100000000;
            14: return 14'b01101100100100;
            16: return 14'b11001111000000;
            20: return 14'b10000000010010;
            21: return 14'b01111100000000;
            24: return 14'b00000000101101;
            default: return 14'b0;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // digit that the upcoming edge starts, or -1 if it is mid-slot
    function automatic int nxt_slot();
        int t;
        t = m_started ? tc + 1 : 0;
        if (t % S != 0) return -1;
        return (t / S) % 12;
    endfunction

    function automatic bit nxt_mid(input int d);
        int t;
        t = m_started ? tc + 1 : 0;
        return (t % S != 0) && ((t / S) % 12 == d);
    endfunction

    task automatic tick(input bit r, input bit we, input int wa, input int wc,
                        input int ml, input bit se);
        exp_t e;
        int   d, c, nl;
        @(negedge clk);
        rst = r; wr_en = we; wr_addr = wa[3:0]; wr_char = wc[4:0];
        msg_len = ml[4:0]; scroll_en = se;
        e.fd = 1'b0;
        if (r) begin
            m_started = 0; tc = 0; m_len = 1; m_off = 0; m_fcnt = 0; m_scroll = 0;
            for (int i = 0; i < 16; i++) m_buf[i] = '0;
            m_sel = '0; m_segm = '0;
        end else begin
            if (!m_started) begin m_started = 1; tc = 0; end
            else tc++;
            if (tc % S == 0) begin
                d = (tc / S) % 12;
                if (d == 0) begin
                    nl = (ml == 0) ? 1 : ((ml > 16) ? 16 : ml);
                    if (tc > 0) e.fd = 1'b1;
                    if (m_scroll) begin
                        m_fcnt++;
                        if (m_fcnt == SD) begin m_fcnt = 0; m_off++; end
                    end else begin
                        m_fcnt = 0; m_off = 0;
                    end
                    if (m_off >= nl) m_off = 0;
                    m_len = nl; m_scroll = se;
                end
                if (m_scroll) c = m_buf[(m_off + d) % m_len];
                else          c = (d < m_len) ? m_buf[d] : 0;
                m_sel  = 12'b1 << d;
                m_segm = font(c);
            end
            if (we) m_buf[wa] = wc[4:0];
        end
        e.sel = m_sel; e.segm = m_segm;
        q.push_back(e);
    endtask

    // monitor: one expected entry per clock edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sel", sel, e.sel);
                chk("segm", segm, e.segm);
                chk("frame_done", frame_done, e.fd);
            end
        end
    end

    initial begin
        int ml, found;
        bit se;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_char = '0; msg_len = '0; scroll_en = 1'b0;
        for (int i = 0; i < 3; i++) tick(1, 0, 0, 0, 0, 0);
        // reset release: blank walk
        for (int i = 0; i < 60; i++) tick(0, 0, 0, 0, 0, 0);
        // static TUX
        tick(0, 1, 0, 20, 3, 0);
        tick(0, 1, 1, 21, 3, 0);
        tick(0, 1, 2, 24, 3, 0);
        for (int i = 0; i < 60; i++) tick(0, 0, 0, 0, 3, 0);
        // collision: write A to addr 1 on the edge starting digit 1
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (nxt_slot() == 1) begin tick(0, 1, 1, 1, 3, 0); found = 1; end
            else tick(0, 0, 0, 0, 3, 0);
        end
        chk("reach_digit1", found, 1);
        for (int i = 0; i < 60; i++) tick(0, 0, 0, 0, 3, 0);
        tick(0, 1, 1, 21, 3, 0);
        // mid-frame msg_len change
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (nxt_slot() == 5) begin tick(0, 0, 0, 0, 8, 0); found = 1; end
            else tick(0, 0, 0, 0, 3, 0);
        end
        chk("reach_digit5", found, 1);
        for (int i = 0; i < 50; i++) tick(0, 0, 0, 0, 8, 0);
        // scrolling
        for (int i = 0; i < 24 * 8; i++) tick(0, 0, 0, 0, 3, 1);
        // reset mid-scroll at offset 2, middle of digit 5
        found = 0;
        for (int i = 0; i < 600 && !found; i++) begin
            if (m_off == 2 && m_scroll && nxt_mid(5)) begin tick(1, 0, 0, 0, 3, 1); found = 1; end
            else tick(0, 0, 0, 0, 3, 1);
        end
        chk("reach_off2", found, 1);
        for (int i = 0; i < 30; i++) tick(0, 0, 0, 0, 3, 1);
        // length clamp
        for (int i = 0; i < 16; i++) tick(0, 1, i, codes[$urandom_range(1, 8)], 0, 0);
        for (int i = 0; i < 50; i++) tick(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 24 * 40; i++) tick(0, 0, 0, 0, 20, 1);
        // random traffic
        ml = 5; se = 1;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 49) == 0) ml = $urandom_range(0, 31);
            if ($urandom_range(0, 99) == 0) se = ~se;
            tick($urandom_range(0, 399) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 15), codes[$urandom_range(0, 10)], ml, se);
        end
        @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/disp_scroll_ctrl.md
# disp_scroll_ctrl

Scan and scroll controller for the 12-digit, 14-segment display. It holds a writable 16-character message buffer and time-multiplexes it onto the display's one-hot digit selects and segment bus. When scrolling is enabled, it rotates the message circularly across the 12 digits at a programmable frame rate. It sits between the host or configuration logic and the display pads, and replaces any hard-wired message sequencing.

## Interface
Parameters:
- SCAN_DIV, 4: clock cycles per digit slot; legal range ≥1.
- SCROLL_DIV, 48: completed frames per scroll step; legal range ≥1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  writes wr_char into buffer[wr_addr] on this edge.
- wr_addr  in  4  buffer index, 0..15.
- wr_char  in  5  character code.
- msg_len  in  5  active message length; sampled at frame boundaries.
- scroll_en  in  1  enables circular scrolling; sampled at frame boundaries.
- sel  out  12  one-hot digit select; bit d drives digit d.
- segm  out  14  segment pattern for the selected digit.
- frame_done  out  1  one-cycle pulse at each frame boundary.

## Operation
- Buffer: 16 × 5-bit registers; reset value 0 (blank). A write is visible to the display from the next slot start that reads that address.
- Font map (combinational):
  - Code 0 → 14'b0.
  - Codes 1..26 → A..Z in the team's standard 14-segment font.
  - Codes 27..31 → 14'b0.
  - Required values: A=14'b11101111000000, J=01111000000000, L=00011100000000, N=01101100100100, P=11001111000000, T=10000000010010, U=01111100000000, X=00000000101101.
- Prescaler: counts 0..SCAN_DIV-1. On wrap, the digit index advances 0..11, and 11 wraps to 0.
- Frame boundary: the edge that starts digit 0. At this edge the block:
  - latches len_q = clamp(msg_len), where 0→1 and >16→16;
  - latches scroll_q = scroll_en;
  - updates the scroll state.
- Character pointer:
  - At digit 0 the pointer loads from offset.
  - Each following digit sets ptr = (ptr+1 == len_q) ? 0 : ptr+1.
  - No divider or modulo operator is used.
- Displayed character:
  - scroll_q=1: buffer[ptr] for every digit; the message repeats circularly.
  - scroll_q=0: buffer[d] for d < len_q; blank for d ≥ len_q.
- Scroll state:
  - While scroll_q=1, frame_cnt increments at each frame boundary.
  - When frame_cnt reaches SCROLL_DIV, frame_cnt clears and offset = (offset+1 == len_q) ? 0 : offset+1.
  - scroll_q=0 clears frame_cnt and offset at the boundary.
  - If offset ≥ new len_q, offset clears to 0.
- Scroll updates take effect only at frame boundaries; a frame never tears.

## Timing
- Reset values: sel=0, segm=0, frame_done=0, digit=0, prescaler=0, offset=0, frame_cnt=0, buffer all 0.
- First edge with rst low: sel=12'b000000000001 and segm loads digit 0's pattern. This is the first frame boundary; it produces no frame_done pulse.
- Slot n starts on edge 1 + n·SCAN_DIV.
  - sel and segm are registered and change only on slot-start edges, always together.
  - Each slot holds its values for exactly SCAN_DIV cycles.
- frame_done is high for the single cycle following each frame boundary except the first after reset. Period = 12·SCAN_DIV cycles.
- Read/write collision: segm is sampled from the buffer value before the edge.
  - A write on a slot-start edge to the address being read displays the old character for that slot.
  - The new character appears the next time that address is scanned.
- msg_len or scroll_en changes mid-frame: no effect until the next frame boundary.
- rst asserted mid-frame: all state returns to reset values on that edge, including the buffer, and scanning restarts at digit 0.

## Test plan
Run all scenarios with SCAN_DIV=2 and SCROLL_DIV=2.
- Reset → sel=0 and segm=0 during reset. After release: sel walks 001, 002, 004 … 800, changing every 2 cycles; segm=0 throughout; first frame_done 24 cycles after the first slot start.
- Static message: write T(20), U(21), X(24) to addresses 0..2; msg_len=3; scroll_en=0 → digit0=10000000010010, digit1=01111100000000, digit2=00000000101101, digits 3..11 = 0.
- Scrolling: same buffer, scroll_en=1.
  - Frames 1–2: digits read T,U,X,T,U,X…
  - Frame 3 after 2 completed frames: U,X,T,U…
  - Then X,T,U…, then T again; the offset wraps at 3.
- Length clamp:
  - msg_len=0 → only digit 0 is non-blank (scroll off).
  - msg_len=20 with scroll on → pointer cycles 0..15 and wraps; offset never exceeds 15.
- Collision and mid-frame change:
  - Write A(1) to address 1 on the edge starting digit 1 → digit 1 shows U this frame and A the next.
  - Change msg_len mid-frame → the blanking pattern changes only at the next boundary.
- Reset mid-scroll: assert rst at offset=2 in the middle of digit 5 → next edge gives sel=0 and segm=0; after release, digit 0 shows blank, since the buffer was cleared.
